// File: rtl/cmd_bundle_packer.sv
// rtl/cmd_bundle_packer.sv - packs DDR4 command entries and write data into 640-bit decoder bundles
module cmd_bundle_packer #(
    parameter int CMD_SLOTS    = 4,
    parameter int SLOT_WIDTH   = 32,
    parameter int WDATA_WIDTH  = 512,
    parameter int OUT_WIDTH    = CMD_SLOTS*SLOT_WIDTH+WDATA_WIDTH,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SLOT_WIDTH-1:0]  s_cmd_data,
    input  logic                   s_cmd_last,
    input  logic                   s_cmd_valid,
    output logic                   s_cmd_ready,
    input  logic [WDATA_WIDTH-1:0] s_wdata,
    input  logic                   s_wdata_valid,
    output logic                   s_wdata_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic [CNT_WIDTH-1:0]   stat_bundles,
    output logic [CNT_WIDTH-1:0]   stat_wr_stalls
);
    localparam int SLOTS_W = CMD_SLOTS*SLOT_WIDTH;
    localparam int CW      = $clog2(CMD_SLOTS);
    localparam int IW      = $clog2(IDLE_TIMEOUT+1)+1;
    localparam logic [IW-1:0] IDLE_TO   = IW'(IDLE_TIMEOUT);
    localparam logic [CW-1:0] LAST_SLOT = CW'(CMD_SLOTS-1);

    logic [SLOTS_W-1:0]     r_slots;
    logic [WDATA_WIDTH-1:0] r_wbuf;
    logic [CW-1:0]          r_cnt;
    logic                   r_has_wr;
    logic [IW-1:0]          r_idle;
    logic                   r_out_valid;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic [CNT_WIDTH-1:0]   r_stat_bundles;
    logic [CNT_WIDTH-1:0]   r_stat_wr_stalls;

    logic                   w_is_wr;
    logic                   w_wr_conflict;
    logic                   w_accept;
    logic                   w_cnt_nz;
    logic [IW-1:0]          w_idle_inc;
    logic                   w_timeout;
    logic                   w_flush;
    logic                   w_stall;
    logic [SLOTS_W-1:0]     w_slots_next;
    logic [WDATA_WIDTH-1:0] w_wbuf_next;
    logic                   w_has_wr_next;
    logic [OUT_WIDTH-1:0]   w_bundle;

    always_comb begin
        w_is_wr       = (s_cmd_data[2:0] == 3'd4);
        w_wr_conflict = s_cmd_valid && w_is_wr && r_has_wr;
        s_cmd_ready   = !rst && !w_wr_conflict && !(w_is_wr && !s_wdata_valid);
        w_accept      = s_cmd_valid && s_cmd_ready;
        s_wdata_ready = w_accept && w_is_wr;
        w_stall       = s_cmd_valid && w_is_wr && !s_cmd_ready;
        w_cnt_nz      = (r_cnt != '0);
        w_idle_inc    = r_idle + IW'(1);
        w_timeout     = (IDLE_TIMEOUT > 0) && w_cnt_nz && !w_accept && (w_idle_inc == IDLE_TO);
        // A conflicting WR closes the open bundle so it can start the next one.
        w_flush       = (w_accept && ((r_cnt == LAST_SLOT) || s_cmd_last))
                      || (w_wr_conflict && w_cnt_nz)
                      || w_timeout;

        w_slots_next  = r_slots;
        w_wbuf_next   = r_wbuf;
        w_has_wr_next = r_has_wr;
        if (w_accept) begin
            w_slots_next[r_cnt*SLOT_WIDTH +: SLOT_WIDTH] = s_cmd_data;
        end
        if (s_wdata_ready) begin
            w_wbuf_next   = s_wdata;
            w_has_wr_next = 1'b1;
        end
        w_bundle = {(w_has_wr_next ? w_wbuf_next : {WDATA_WIDTH{1'b0}}), w_slots_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots          <= '0;
            r_wbuf           <= '0;
            r_cnt            <= '0;
            r_has_wr         <= 1'b0;
            r_idle           <= '0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_stat_bundles   <= '0;
            r_stat_wr_stalls <= '0;
        end else begin
            r_out_valid <= w_flush;
            if (w_flush) begin
                r_out_data     <= w_bundle;
                r_slots        <= '0;
                r_wbuf         <= '0;
                r_cnt          <= '0;
                r_has_wr       <= 1'b0;
                r_idle         <= '0;
                r_stat_bundles <= r_stat_bundles + CNT_WIDTH'(1);
            end else begin
                r_slots  <= w_slots_next;
                r_wbuf   <= w_wbuf_next;
                r_has_wr <= w_has_wr_next;
                r_cnt    <= w_accept ? r_cnt + CW'(1) : r_cnt;
                // Idle time only accumulates while a partial bundle is waiting.
                r_idle   <= (w_accept || !w_cnt_nz) ? '0 : w_idle_inc;
            end
            if (w_stall) begin
                r_stat_wr_stalls <= r_stat_wr_stalls + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign stat_bundles   = r_stat_bundles;
    assign stat_wr_stalls = r_stat_wr_stalls;
endmodule

// File: doc/cmd_bundle_packer.md
Name: cmd_bundle_packer

Overview:
- Upstream neighbour of the DDR4 command decoder. Packs a serial stream of 32-bit DDR4 command entries and their 512-bit write-data beats into the 640-bit bundle format the decoder consumes.
- Bundle layout: slots in [127:0], write data in [639:128].
- Fills up to 4 command slots per bundle, allows at most one WR per bundle, and pads unused slots with NOP.
- Emits a single-cycle valid pulse per bundle. The decoder has no backpressure.

Parameters:
- CMD_SLOTS, 4, command slots per bundle (fixed at 4 for decoder compatibility).
- SLOT_WIDTH, 32, bits per command slot.
- WDATA_WIDTH, 512, write-data width.
- OUT_WIDTH, CMD_SLOTS*SLOT_WIDTH+WDATA_WIDTH (640), bundle width.
- IDLE_TIMEOUT, 16, consecutive idle cycles before a partial bundle is flushed; 0 disables the timeout.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_cmd_data  in  32  command entry. Bits [2:0] are the type: 0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR, 5 REF, 6 ZQ. Bits [31:3] pass through untouched.
- s_cmd_last  in  1  force the bundle to emit after this entry is placed.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accepted when valid&&ready.
- s_wdata  in  512  write data for the next WR command.
- s_wdata_valid  in  1  write data valid.
- s_wdata_ready  out  1  write data consumed; pulses together with WR acceptance.
- out_data  out  640  bundle to the decoder.
- out_valid  out  1  one-cycle bundle strobe.
- stat_bundles  out  CNT_WIDTH  bundles emitted; wraps.
- stat_wr_stalls  out  CNT_WIDTH  cycles a WR was held off for missing wdata or a WR conflict; wraps.

Behaviour:
- State:
  - slot buffer (128b), wdata buffer (512b);
  - fill count cnt (0..3 between cycles);
  - has_wr flag;
  - idle counter.
- Reset values:
  - out_valid=0, out_data=0, s_cmd_ready and s_wdata_ready combinationally low when their conditions are false;
  - cnt=0, has_wr=0, idle=0, buffers=0, stat_*=0.
- is_wr = s_cmd_data[2:0]==4.
- wr_conflict = s_cmd_valid && is_wr && has_wr.
- s_cmd_ready = !rst && !wr_conflict && !(is_wr && !s_wdata_valid). Ready may depend on valid.
- s_wdata_ready = s_cmd_valid && s_cmd_ready && is_wr. Write data is consumed only with its WR.
- Accept: the entry is written into slot cnt at bits [cnt*32 +: 32]; the first entry goes to slot 0.
  - If WR: wdata is latched into the wdata buffer and has_wr is set.
  - cnt increments and idle clears.
- Emit trigger on accept: the placed entry fills slot 3, or s_cmd_last=1.
  - The bundle is formed with that entry included.
  - Next cycle: out_valid=1, out_data = {wdata_buf or 0 if !has_wr, slots with unused slots zero (NOP)}.
  - Buffers clear: cnt=0, has_wr=0, idle=0.
  - Latency: last accepted entry to out_valid is 1 cycle.
- Conflict flush: wr_conflict with cnt>0.
  - The current bundle emits (out_valid next cycle) and the WR is not accepted this cycle.
  - The WR is accepted into slot 0 of the fresh bundle on the following cycle at the earliest.
- Timeout flush: IDLE_TIMEOUT>0, cnt>0, and no accept for IDLE_TIMEOUT consecutive cycles.
  - Flush on the cycle idle reaches IDLE_TIMEOUT; out_valid follows next cycle.
  - idle counts only while cnt>0 and no accept.
- Simultaneous triggers produce exactly one flush and one out_valid pulse.
- An accept in a cycle cancels a pending timeout for that cycle.
- cnt==0: no flush is ever emitted; empty bundles are never produced.
- out_valid is high for exactly 1 cycle per bundle; back-to-back bundles on consecutive cycles are allowed.
- out_data holds its value after the pulse until the next bundle.
- stat_bundles increments on each out_valid.
- stat_wr_stalls increments each cycle s_cmd_valid && is_wr && !s_cmd_ready.
- Reset mid-operation discards the partial bundle with no out_valid. Any pending out_valid for that cycle is suppressed.

Test Plan:
- 4 entries PRE(0x09), ACT(0x12), RD(0x23), NOP(0x00) on consecutive cycles → one out_valid on the cycle after the 4th; out_data[127:0]=0x00000000_00000023_00000012_00000009; wdata field 0; stat_bundles=1.
- ACT, then WR with wdata=0xA5 repeated, then s_cmd_last RD → bundle slots {RD,WR,ACT} in slots 2,1,0; slot 3=0; out_data[639:128]=0xA5..A5; s_wdata_ready pulsed once, with the WR.
- WR(A), WR(B) back-to-back, both with wdata valid → second WR ready=0 for 1 cycle; bundle1 = {WR(A) slot0, wdata A}; WR(B) goes to slot0 of bundle2; stat_wr_stalls=1.
- Single ACT, then no valid, IDLE_TIMEOUT=16 → out_valid exactly 17 cycles after the ACT acceptance; slots 1-3 zero.
- WR offered with s_wdata_valid=0 for 5 cycles, then 1 → ready low for 5 cycles; stat_wr_stalls=5; accepted on cycle 6; no premature timeout flush while cnt=0.
- 2 entries accepted, then rst asserted 1 cycle → no out_valid; a next single entry with last=1 appears alone in slot 0; stat_bundles=1.
